// File: rtl/riscv_dcache_ctrl_nway.sv
// -----------------------------------------------------------------------------
// riscv_dcache_ctrl_nway
// N-way set-associative data-cache controller FSM. It sits between the CPU
// memory stage, the dcache data/tag arrays and the DRAM interface.
// It handles hit access, victim choice, multi-beat write-back and refill, and
// the AMO read-modify-write sequence. It requests pipeline stalls through
// dcache_stall.
//
// Parameters : WAYS/WAY_W (ways, log2), BEATS/BEAT_W (DRAM beats per line, log2)
// Inputs     : clk, rst (sync, active high), cpu_rden/cpu_wren/cpu_amoen,
//              glob_stall, hit_vec/valid_vec/dirty_vec (indexed set),
//              mem_ready (per-beat DRAM acknowledge)
// Outputs    : data array control (cache_rden, cache_wren, cache_insel, way_sel,
//              beat_idx), DRAM control (mem_rden, mem_wren, tag_sel), tag write
//              (replace_tag, set_valid, set_dirty), dcache_stall, AMO enables,
//              state_dbg / rr_ptr_dbg (FSM state and round-robin pointer)
// Option     : `define DCACHE_PERF_EN adds hit_cnt, miss_cnt, wb_cnt outputs
//              (32-bit saturating event counters).
//
// Handshake: one DRAM beat is transferred on each cycle where the controller
// requests (mem_rden/mem_wren=1) and mem_ready=1. mem_ready is ignored in every
// other state.
//
// state_dbg encoding: 0 IDLE, 1 COMPARE_TAG, 2 WRITE_BACK, 3 ALLOCATE,
// 4 CACHE_ACCESS, 5 AMO_MODIFY, 6 AMO_STORE.
// -----------------------------------------------------------------------------
module riscv_dcache_ctrl_nway #(
   parameter int WAYS   = 2,
   parameter int WAY_W  = 1,
   parameter int BEATS  = 4,
   parameter int BEAT_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_rden,
   input  logic              cpu_wren,
   input  logic              cpu_amoen,
   input  logic              glob_stall,
   input  logic [WAYS-1:0]   hit_vec,
   input  logic [WAYS-1:0]   valid_vec,
   input  logic [WAYS-1:0]   dirty_vec,
   input  logic              mem_ready,
   output logic              cache_rden,
   output logic              cache_wren,
   output logic [1:0]        cache_insel,
   output logic [WAY_W-1:0]  way_sel,
   output logic [BEAT_W-1:0] beat_idx,
   output logic              mem_rden,
   output logic              mem_wren,
   output logic              set_dirty,
   output logic              set_valid,
   output logic              replace_tag,
   output logic              tag_sel,
   output logic              dcache_stall,
   output logic              amo_buffer_en,
   output logic              amo_unit_en,
   output logic [2:0]        state_dbg,
   output logic [WAY_W-1:0]  rr_ptr_dbg
`ifdef DCACHE_PERF_EN
   ,
   output logic [31:0]       hit_cnt,
   output logic [31:0]       miss_cnt,
   output logic [31:0]       wb_cnt
`endif
);

   localparam logic [2:0] S_IDLE         = 3'd0;
   localparam logic [2:0] S_COMPARE_TAG  = 3'd1;
   localparam logic [2:0] S_WRITE_BACK   = 3'd2;
   localparam logic [2:0] S_ALLOCATE     = 3'd3;
   localparam logic [2:0] S_CACHE_ACCESS = 3'd4;
   localparam logic [2:0] S_AMO_MODIFY   = 3'd5;
   localparam logic [2:0] S_AMO_STORE    = 3'd6;

   logic [2:0]        state, state_nxt;
   logic              rd_r, wr_r, amo_r;
   logic [WAY_W-1:0]  rr_ptr, victim_way, hit_way, victim_nxt;
   logic [BEAT_W-1:0] beat_cnt;
   logic              hit, any_cpu, last_beat, victim_dirty;

   assign hit          = |hit_vec;
   assign any_cpu      = cpu_rden | cpu_wren | cpu_amoen;
   assign last_beat    = (beat_cnt == BEAT_W'(BEATS - 1));
   assign victim_dirty = dirty_vec[victim_nxt];
   assign state_dbg    = state;
   assign rr_ptr_dbg   = rr_ptr;

   // Downward scans so the lowest-index match wins.
   always_comb begin
      hit_way    = '0;
      victim_nxt = rr_ptr;
      for (int i = WAYS - 1; i >= 0; i--) begin
         if (hit_vec[i])    hit_way    = WAY_W'(i);
         if (!valid_vec[i]) victim_nxt = WAY_W'(i);
      end
   end

   always_comb begin
      state_nxt     = state;
      cache_rden    = 1'b0;
      cache_wren    = 1'b0;
      cache_insel   = 2'b00;
      way_sel       = '0;
      beat_idx      = '0;
      mem_rden      = 1'b0;
      mem_wren      = 1'b0;
      set_dirty     = 1'b0;
      set_valid     = 1'b0;
      replace_tag   = 1'b0;
      tag_sel       = 1'b0;
      dcache_stall  = 1'b0;
      amo_buffer_en = 1'b0;
      amo_unit_en   = 1'b0;
      // Outputs are forced quiet while rst is high, before the state register
      // has been cleared by the reset edge.
      if (!rst) begin
         case (state)
            S_IDLE: begin
               if (any_cpu) state_nxt = S_COMPARE_TAG;
            end
            S_COMPARE_TAG: begin
               if (hit) begin
                  way_sel   = hit_way;
                  set_dirty = 1'b1;
                  set_valid = 1'b1;
                  if (amo_r) begin
                     cache_rden    = 1'b1;
                     amo_buffer_en = 1'b1;
                     replace_tag   = 1'b1;
                     dcache_stall  = 1'b1;
                     state_nxt     = S_AMO_MODIFY;
                  end else begin
                     cache_rden  = rd_r;
                     cache_wren  = wr_r;
                     replace_tag = wr_r;
                     state_nxt   = (glob_stall || any_cpu) ? S_COMPARE_TAG : S_IDLE;
                  end
               end else begin
                  way_sel      = victim_way;
                  dcache_stall = 1'b1;
                  state_nxt    = victim_dirty ? S_WRITE_BACK : S_ALLOCATE;
               end
            end
            S_WRITE_BACK: begin
               way_sel      = victim_way;
               cache_rden   = 1'b1;
               mem_wren     = 1'b1;
               tag_sel      = 1'b1;
               beat_idx     = beat_cnt;
               dcache_stall = 1'b1;
               if (mem_ready && last_beat) state_nxt = S_ALLOCATE;
            end
            S_ALLOCATE: begin
               way_sel      = victim_way;
               mem_rden     = 1'b1;
               beat_idx     = beat_cnt;
               dcache_stall = 1'b1;
               if (mem_ready) begin
                  cache_wren  = 1'b1;
                  cache_insel = 2'b01;
                  if (last_beat) begin
                     replace_tag = 1'b1;
                     set_valid   = 1'b1;
                     set_dirty   = wr_r | amo_r;
                     state_nxt   = S_CACHE_ACCESS;
                  end
               end
            end
            S_CACHE_ACCESS: begin
               way_sel = victim_way;
               if (amo_r) begin
                  cache_rden    = 1'b1;
                  amo_buffer_en = 1'b1;
                  dcache_stall  = 1'b1;
                  state_nxt     = S_AMO_MODIFY;
               end else begin
                  cache_rden = rd_r;
                  cache_wren = wr_r;
                  set_valid  = 1'b1;
                  state_nxt  = (glob_stall || any_cpu) ? S_COMPARE_TAG : S_IDLE;
               end
            end
            S_AMO_MODIFY: begin
               way_sel       = victim_way;
               cache_insel   = 2'b10;
               amo_buffer_en = 1'b1;
               amo_unit_en   = 1'b1;
               dcache_stall  = 1'b1;
               state_nxt     = S_AMO_STORE;
            end
            S_AMO_STORE: begin
               way_sel     = victim_way;
               cache_wren  = 1'b1;
               cache_insel = 2'b10;
               amo_unit_en = 1'b1;
               if (glob_stall)   state_nxt = S_AMO_STORE;
               else if (any_cpu) state_nxt = S_COMPARE_TAG;
               else              state_nxt = S_IDLE;
            end
            default: begin
               dcache_stall = 1'b1;
               state_nxt    = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         rd_r       <= 1'b0;
         wr_r       <= 1'b0;
         amo_r      <= 1'b0;
         rr_ptr     <= '0;
         victim_way <= '0;
         beat_cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (!glob_stall) begin
            rd_r  <= cpu_rden;
            wr_r  <= cpu_wren;
            amo_r <= cpu_amoen;
         end
         // Beat counting deliberately ignores glob_stall.
         case (state)
            S_COMPARE_TAG: begin
               if (!hit) begin
                  victim_way <= victim_nxt;
                  beat_cnt   <= '0;
               end
            end
            S_WRITE_BACK: begin
               if (mem_ready) beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            end
            S_ALLOCATE: begin
               if (mem_ready) begin
                  beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
                  if (last_beat)
                     rr_ptr <= (rr_ptr == WAY_W'(WAYS - 1)) ? '0 : rr_ptr + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef DCACHE_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
         wb_cnt   <= '0;
      end else if (state == S_COMPARE_TAG) begin
         if (hit && !glob_stall && hit_cnt != 32'hFFFF_FFFF)
            hit_cnt <= hit_cnt + 32'd1;
         if (!hit && miss_cnt != 32'hFFFF_FFFF)
            miss_cnt <= miss_cnt + 32'd1;
         if (!hit && victim_dirty && wb_cnt != 32'hFFFF_FFFF)
            wb_cnt <= wb_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_riscv_dcache_ctrl_nway.sv
// -----------------------------------------------------------------------------
// tb_riscv_dcache_ctrl_nway
// Drives whole cache transactions (load/store/AMO, hit or miss) into the
// controller. A transaction-level model derives the expected per-cycle output
// pattern from the access rules: hit way, victim pick, write-back need, beat
// sequencing and the round-robin pointer.
// -----------------------------------------------------------------------------
module tb_riscv_dcache_ctrl_nway;

  localparam logic [2:0] S_IDLE = 3'd0, S_CT = 3'd1, S_WB = 3'd2, S_AL = 3'd3,
                         S_CA = 3'd4, S_AM = 3'd5, S_AS = 3'd6;
  localparam int BEATS = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, cpu_rden, cpu_wren, cpu_amoen, glob_stall, mem_ready;
  logic [1:0] hit_vec, valid_vec, dirty_vec;
  logic       cache_rden, cache_wren, mem_rden, mem_wren, set_dirty, set_valid;
  logic       replace_tag, tag_sel, dcache_stall, amo_buffer_en, amo_unit_en;
  logic [1:0] cache_insel, beat_idx;
  logic [0:0] way_sel, rr_ptr_dbg;
  logic [2:0] state_dbg;
  logic [15:0] obs;

  riscv_dcache_ctrl_nway #(.WAYS(2), .WAY_W(1), .BEATS(4), .BEAT_W(2)) dut (
    .clk(clk), .rst(rst), .cpu_rden(cpu_rden), .cpu_wren(cpu_wren),
    .cpu_amoen(cpu_amoen), .glob_stall(glob_stall), .hit_vec(hit_vec),
    .valid_vec(valid_vec), .dirty_vec(dirty_vec), .mem_ready(mem_ready),
    .cache_rden(cache_rden), .cache_wren(cache_wren), .cache_insel(cache_insel),
    .way_sel(way_sel), .beat_idx(beat_idx), .mem_rden(mem_rden),
    .mem_wren(mem_wren), .set_dirty(set_dirty), .set_valid(set_valid),
    .replace_tag(replace_tag), .tag_sel(tag_sel), .dcache_stall(dcache_stall),
    .amo_buffer_en(amo_buffer_en), .amo_unit_en(amo_unit_en),
    .state_dbg(state_dbg), .rr_ptr_dbg(rr_ptr_dbg)
  );

  assign obs = {cache_rden, cache_wren, cache_insel, way_sel, beat_idx, mem_rden,
                mem_wren, set_dirty, set_valid, replace_tag, tag_sel, dcache_stall,
                amo_buffer_en, amo_unit_en};

  int n_pass = 0;
  int n_total = 0;

  // model state
  logic m_rr = 1'b0;
  logic m_vw = 1'b0;

  function automatic logic [15:0] ev(input logic rden, wren, input logic [1:0] insel,
                                     input logic way, input logic [1:0] beat,
                                     input logic mrd, mwr, sd, sv, rt, ts, st, ab, au);
    return {rden, wren, insel, way, beat, mrd, mwr, sd, sv, rt, ts, st, ab, au};
  endfunction

  function automatic logic lowest_set(input logic [1:0] v);
    return v[0] ? 1'b0 : 1'b1;
  endfunction

  function automatic logic pick_victim(input logic [1:0] vv, input logic rr);
    if (!vv[0]) return 1'b0;
    if (!vv[1]) return 1'b1;
    return rr;
  endfunction

  // driver: inputs are already set; sample on negedge, then advance one edge
  task automatic step(input logic [15:0] e, input logic [2:0] es, input string tag);
    @(negedge clk);
    n_total++;
    assert (obs === e) n_pass++;
    else $error("FAIL %s: outputs observed %h expected %h", tag, obs, e);
    n_total++;
    assert (state_dbg === es) n_pass++;
    else $error("FAIL %s: state observed %0d expected %0d", tag, state_dbg, es);
    @(posedge clk);
    #1;
  endtask

  task automatic check_rr(input string tag);
    @(negedge clk);
    n_total++;
    assert (rr_ptr_dbg === m_rr) n_pass++;
    else $error("FAIL %s: rr_ptr observed %0d expected %0d", tag, rr_ptr_dbg, m_rr);
    @(posedge clk);
    #1;
  endtask

  task automatic amo_tail(input int hold, input string nm);
    glob_stall = 1'b1;
    mem_ready  = 1'($urandom_range(0, 1));
    step(ev(0,0,2'b10,m_vw,0,0,0,0,0,0,0,1,1,1), S_AM, {nm, ":amo_modify"});
    for (int i = 0; i < hold; i++) begin
      glob_stall = 1'b1;
      step(ev(0,1,2'b10,m_vw,0,0,0,0,0,0,0,0,0,1), S_AS, {nm, ":amo_store_hold"});
    end
    glob_stall = 1'b0;
    step(ev(0,1,2'b10,m_vw,0,0,0,0,0,0,0,0,0,1), S_AS, {nm, ":amo_store"});
  endtask

  // kind: 0 load, 1 store, 2 AMO. gap: idle cycles before each mem_ready.
  task automatic run_txn(input int kind, input logic [1:0] hv, vv, dv,
                         input int gap, input int hold, input string nm);
    logic rd, wr, am, hit, hw, vic, wb, last;
    rd = (kind == 0); wr = (kind == 1); am = (kind == 2);
    hit = |hv;
    hw  = lowest_set(hv);
    hit_vec = hv; valid_vec = vv; dirty_vec = dv;
    glob_stall = 1'b0;
    mem_ready  = 1'($urandom_range(0, 1));
    cpu_rden = rd; cpu_wren = wr; cpu_amoen = am;
    step('0, S_IDLE, {nm, ":idle"});
    cpu_rden = 1'b0; cpu_wren = 1'b0; cpu_amoen = 1'b0;
    mem_ready = 1'($urandom_range(0, 1));
    if (hit && !am) begin
      glob_stall = 1'b0;
      step(ev(rd,wr,0,hw,0,0,0,1,1,wr,0,0,0,0), S_CT, {nm, ":hit"});
      return;
    end
    glob_stall = 1'b1;
    if (hit) begin
      step(ev(1,0,0,hw,0,0,0,1,1,1,0,1,1,0), S_CT, {nm, ":amo_hit"});
      amo_tail(hold, nm);
      return;
    end
    vic = pick_victim(vv, m_rr);
    wb  = dv[vic];
    step(ev(0,0,0,m_vw,0,0,0,0,0,0,0,1,0,0), S_CT, {nm, ":miss"});
    m_vw = vic;
    if (wb) begin
      for (int b = 0; b < BEATS; b++) begin
        for (int g = 0; g < gap; g++) begin
          mem_ready = 1'b0;
          step(ev(1,0,0,vic,2'(b),0,1,0,0,0,1,1,0,0), S_WB, {nm, ":wb_wait"});
        end
        mem_ready = 1'b1;
        step(ev(1,0,0,vic,2'(b),0,1,0,0,0,1,1,0,0), S_WB, $sformatf("%s:wb_beat%0d", nm, b));
      end
    end
    for (int b = 0; b < BEATS; b++) begin
      last = (b == BEATS - 1);
      for (int g = 0; g < gap; g++) begin
        mem_ready = 1'b0;
        step(ev(0,0,0,vic,2'(b),1,0,0,0,0,0,1,0,0), S_AL, {nm, ":al_wait"});
      end
      mem_ready = 1'b1;
      step(ev(0,1,2'b01,vic,2'(b),1,0,last & (wr | am),last,last,0,1,0,0), S_AL,
           $sformatf("%s:al_beat%0d", nm, b));
    end
    m_rr = ~m_rr;
    mem_ready = 1'($urandom_range(0, 1));
    if (!am) begin
      glob_stall = 1'b0;
      step(ev(rd,wr,0,vic,0,0,0,0,1,0,0,0,0,0), S_CA, {nm, ":cache_access"});
    end else begin
      step(ev(1,0,0,vic,0,0,0,0,0,0,0,1,1,0), S_CA, {nm, ":cache_access_amo"});
      amo_tail(hold, nm);
    end
  endtask

  initial begin
    rst = 1'b1; cpu_rden = 1'b0; cpu_wren = 1'b0; cpu_amoen = 1'b0;
    glob_stall = 1'b0; mem_ready = 1'b0;
    hit_vec = '0; valid_vec = '0; dirty_vec = '0;
    repeat (2) @(posedge clk);
    #1;
    step('0, S_IDLE, "reset_held");
    rst = 1'b0;
    step('0, S_IDLE, "reset_state");
    check_rr("reset_rr");

    // directed steps
    run_txn(0, 2'b10, 2'b11, 2'b00, 0, 0, "load_hit_way1");
    step('0, S_IDLE, "load_hit_back_idle");
    run_txn(1, 2'b00, 2'b11, 2'b01, 0, 0, "store_miss_wb");
    check_rr("store_miss_rr");
    run_txn(0, 2'b00, 2'b01, 2'b10, 0, 0, "load_miss_inval1");
    check_rr("load_miss_rr");
    run_txn(2, 2'b01, 2'b11, 2'b00, 0, 3, "amo_hit_hold3");
    run_txn(0, 2'b00, 2'b11, 2'b00, 2, 0, "load_miss_slow_ready");
    run_txn(2, 2'b00, 2'b11, 2'b11, 1, 1, "amo_miss_wb");
    check_rr("amo_miss_rr");

    // randomized transactions
    for (int t = 0; t < 20; t++) begin
      int kind, c, gap, hold;
      logic [1:0] hv, vv, dv;
      kind = $urandom_range(0, 2);
      c    = $urandom_range(0, 3);
      hv   = (c == 0) ? 2'b00 : (c == 1) ? 2'b01 : (c == 2) ? 2'b10 : 2'b11;
      vv   = 2'($urandom_range(0, 3)) | hv;
      dv   = 2'($urandom_range(0, 3));
      gap  = $urandom_range(0, 2);
      hold = $urandom_range(0, 2);
      run_txn(kind, hv, vv, dv, gap, hold, $sformatf("rand%0d", t));
      check_rr($sformatf("rand%0d_rr", t));
    end

    // reset in the middle of a refill, beat counter at 2
    hit_vec = 2'b00; valid_vec = 2'b11; dirty_vec = 2'b00;
    glob_stall = 1'b0; mem_ready = 1'b0; cpu_rden = 1'b1;
    step('0, S_IDLE, "rstmid:idle");
    cpu_rden = 1'b0; glob_stall = 1'b1;
    step(ev(0,0,0,m_vw,0,0,0,0,0,0,0,1,0,0), S_CT, "rstmid:miss");
    m_vw = m_rr;
    mem_ready = 1'b1;
    step(ev(0,1,2'b01,m_vw,2'd0,1,0,0,0,0,0,1,0,0), S_AL, "rstmid:beat0");
    step(ev(0,1,2'b01,m_vw,2'd1,1,0,0,0,0,0,1,0,0), S_AL, "rstmid:beat1");
    rst = 1'b1; mem_ready = 1'b0;
    step('0, S_AL, "rstmid:during_reset");
    rst = 1'b0; glob_stall = 1'b0;
    m_rr = 1'b0; m_vw = 1'b0;
    step('0, S_IDLE, "rstmid:after_reset");
    check_rr("rstmid:rr");
    run_txn(0, 2'b00, 2'b11, 2'b00, 0, 0, "post_reset_miss");
    step('0, S_IDLE, "final_idle");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/riscv_dcache_ctrl_nway.md
Name: riscv_dcache_ctrl_nway

Overview:
Parametrised N-way set-associative data-cache controller FSM. It replaces the single-way, single-beat controller. It adds way selection, victim choice, multi-beat line write-back and refill, and keeps the AMO read-modify-write flow. It sits between the CPU memory stage, the dcache data/tag arrays and the DRAM interface, and drives dcache_stall into the global stall logic.

Parameters:
WAYS, 2, number of ways (power of 2, >=1)
WAY_W, 1, log2(WAYS), minimum 1
BEATS, 4, DRAM beats per cache line (power of 2, >=1)
BEAT_W, 2, log2(BEATS), minimum 1

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
cpu_rden  in  1  CPU load request
cpu_wren  in  1  CPU store request
cpu_amoen  in  1  CPU AMO request
glob_stall  in  1  global pipeline stall
hit_vec  in  WAYS  per-way tag match (already qualified by valid)
valid_vec  in  WAYS  per-way valid bits of the indexed set
dirty_vec  in  WAYS  per-way dirty bits of the indexed set
mem_ready  in  1  DRAM per-beat acknowledge
cache_rden  out  1  data array read
cache_wren  out  1  data array write
cache_insel  out  2  00 CPU, 01 DRAM, 10 AMO unit
way_sel  out  WAY_W  way addressed by the array access
beat_idx  out  BEAT_W  line beat addressed during WB/refill
mem_rden  out  1  DRAM read request
mem_wren  out  1  DRAM write request
set_dirty  out  1  dirty value written with the tag
set_valid  out  1  valid value written with the tag
replace_tag  out  1  tag/valid/dirty write strobe for way_sel
tag_sel  out  1  1: DRAM address uses victim tag (write-back)
dcache_stall  out  1  stall request to the pipeline
amo_buffer_en  out  1  capture cache read data for the AMO unit
amo_unit_en  out  1  enable the AMO ALU

Behaviour:
- The reset is synchronous. On rst, the state is IDLE, the request registers and the victim pointer are 0, beat_cnt is 0 and victim_way is 0. Every output is 0 during and after reset until a request arrives.
- Request registers rd_r/wr_r/amo_r load from cpu_* on every clk where glob_stall=0 and hold otherwise.
- hit = |hit_vec. hit_way = the lowest-index set bit, so multiple hits resolve to the lowest index.
- Victim choice is made at the COMPARE_TAG miss cycle and latched into victim_way:
  - the lowest-index way with valid_vec=0;
  - otherwise rr_ptr. rr_ptr increments modulo WAYS on every completed refill.
- way_sel = hit_way in COMPARE_TAG on a hit, otherwise victim_way.
- IDLE: all outputs are 0. If any cpu_* is set, the next state is COMPARE_TAG.
- COMPARE_TAG, hit and amo_r=0:
  - cache_rden=rd_r, cache_wren=wr_r, replace_tag=wr_r, set_dirty=1, set_valid=1, stall=0.
  - Next state: COMPARE_TAG if glob_stall or any cpu_* is set, else IDLE.
- COMPARE_TAG, hit and amo_r=1:
  - cache_rden=1, amo_buffer_en=1, replace_tag=1, set_dirty=1, set_valid=1, stall=1.
  - Next state: AMO_MODIFY.
- COMPARE_TAG, miss with dirty_vec[victim]=1: stall=1, next state WRITE_BACK, beat_cnt=0.
- COMPARE_TAG, miss with a clean victim: stall=1, next state ALLOCATE, beat_cnt=0.
- WRITE_BACK: cache_rden=1, mem_wren=1, tag_sel=1, beat_idx=beat_cnt, stall=1.
  - On mem_ready, beat_cnt increments.
  - mem_ready on beat BEATS-1 moves to ALLOCATE with beat_cnt=0.
- ALLOCATE: mem_rden=1, stall=1, beat_idx=beat_cnt.
  - On mem_ready: cache_wren=1, insel=01, beat_cnt increments.
  - On the last beat, also replace_tag=1, set_valid=1, set_dirty=wr_r|amo_r, then rr_ptr advances and the next state is CACHE_ACCESS.
- CACHE_ACCESS, amo_r=0: same outputs and transitions as a COMPARE_TAG non-AMO hit, with set_dirty=0 and replace_tag=0.
- CACHE_ACCESS, amo_r=1: cache_rden=1, amo_buffer_en=1, stall=1, next state AMO_MODIFY.
- AMO_MODIFY: insel=10, amo_buffer_en=1, amo_unit_en=1, stall=1, next state AMO_STORE.
- AMO_STORE:
  - cache_wren=1, insel=10, amo_unit_en=1, stall=0.
  - Next state: AMO_STORE if glob_stall, else COMPARE_TAG if any cpu_* is set, else IDLE.
- mem_ready outside WRITE_BACK/ALLOCATE is ignored.
- glob_stall does not freeze the WRITE_BACK or ALLOCATE beat counting.
- Illegal state: outputs 0 except dcache_stall=1, next state IDLE.
- beat_cnt wraps to 0 after beat BEATS-1. With BEATS=1 each phase is a single beat.

Optional Feature:
Macro DCACHE_PERF_EN. When defined, the block adds three 32-bit outputs:
- hit_cnt: counts COMPARE_TAG cycles with hit=1 and glob_stall=0.
- miss_cnt: counts transitions into WRITE_BACK/ALLOCATE from COMPARE_TAG.
- wb_cnt: counts WRITE_BACK entries.

The counters saturate at 0xFFFFFFFF and clear on rst. When the macro is not defined, these ports and registers do not exist.

Test Plan:
- Reset mid-ALLOCATE with beat_cnt=2 -> next cycle state IDLE, all outputs 0, rr_ptr=0.
- WAYS=2, load with hit_vec=2'b10 -> COMPARE_TAG gives cache_rden=1, way_sel=1, dcache_stall=0; no DRAM activity.
- Store miss, valid_vec=2'b11, dirty_vec=2'b01, rr_ptr=0, BEATS=4:
  - WRITE_BACK for 4 mem_ready pulses with beat_idx 0..3 and tag_sel=1;
  - then ALLOCATE for 4 refill writes;
  - last beat has replace_tag=1 and set_dirty=1;
  - then CACHE_ACCESS with cache_wren=1 and rr_ptr=1.
- Load miss, valid_vec=2'b01 -> victim way 1, no write-back, 4 refill beats, set_dirty=0.
- AMO hit -> sequence COMPARE_TAG(amo_buffer_en) -> AMO_MODIFY(amo_unit_en, insel=10) -> AMO_STORE(cache_wren=1, stall=0). With glob_stall=1 held for 3 cycles, the FSM stays in AMO_STORE for 3 cycles.
- mem_ready pulses 1 cycle per 3 during ALLOCATE -> beat_idx advances only on ready, stall is held throughout, and exactly BEATS data writes occur.
